// File: rtl/responder_arbiter.sv
// responder_arbiter: four-player quiz responder. The first debounced button press after the
// host arms the round wins, and an answer timer then counts down in ticks.
//
// Optional feature: define RESPONDER_FOUL_DETECT_EN to flag presses made in IDLE (foul) and
// to exclude fouled players from arbitration while ARMED. When it is undefined, foul stays 0.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   btn[3:0]   in   raw player buttons (1 = pressed), asynchronous to clk
//   start      in   host arm request (level)
//   clear      in   host clear request (level); has priority over start and presses
//   win[3:0]   out  one-hot winning player, zero when there is no winner
//   state[1:0] out  0 IDLE, 1 ARMED, 2 LOCKED, 3 TIMEOUT
//   time_left  out  answer ticks remaining
//   timeout    out  one-cycle pulse when time_left reaches 0
//   foul[3:0]  out  sticky early-press flags
module responder_arbiter #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TICK_DIV   = 10,
  parameter int unsigned ANS_TICKS  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       start,
  input  logic       clear,
  output logic [3:0] win,
  output logic [1:0] state,
  output logic [7:0] time_left,
  output logic       timeout,
  output logic [3:0] foul
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DebW-1:0] DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(TICK_DIV - 1);
  localparam logic [7:0]      AnsTicks = 8'(ANS_TICKS);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StLocked  = 2'd2,
    StTimeout = 2'd3
  } state_e;

  // Input conditioning: 2-flop synchronizer, per-bit debouncer, rising-edge detect.
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      deb_q, deb_prev_q;
  logic [DebW-1:0] deb_cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        // Count consecutive samples that disagree with the debounced level; any agreeing
        // sample restarts the count.
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DebLast) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic [3:0] press;
  logic [3:0] foul_set;
  logic [3:0] eligible;
  logic [3:0] grant;

  assign press = deb_q & ~deb_prev_q;

`ifdef RESPONDER_FOUL_DETECT_EN
  assign foul_set = press;
`else
  assign foul_set = 4'b0000;
`endif

  // foul_q is always zero without the feature, so nobody is ever excluded.
  logic [3:0] foul_q;
  assign eligible = press & ~foul_q;
  // Isolate the lowest set bit: bit 0 has the highest priority.
  assign grant    = eligible & (~eligible + 4'd1);

  state_e          state_q;
  logic [3:0]      win_q;
  logic [7:0]      time_left_q;
  logic            timeout_q;
  logic [DivW-1:0] div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      win_q       <= '0;
      time_left_q <= '0;
      timeout_q   <= 1'b0;
      div_q       <= '0;
      foul_q      <= '0;
    end else if (clear) begin
      state_q     <= StIdle;
      win_q       <= '0;
      time_left_q <= '0;
      timeout_q   <= 1'b0;
      div_q       <= '0;
      foul_q      <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          foul_q <= foul_q | foul_set;
          if (start) state_q <= StArmed;
        end
        StArmed: begin
          if (|grant) begin
            state_q     <= StLocked;
            win_q       <= grant;
            time_left_q <= AnsTicks;
            div_q       <= '0;
          end
        end
        StLocked: begin
          if (div_q == DivLast) begin
            div_q       <= '0;
            time_left_q <= time_left_q - 8'd1;
            if (time_left_q == 8'd1) begin
              timeout_q <= 1'b1;
              state_q   <= StTimeout;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        StTimeout: begin
          // Hold win and time_left until clear.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign win       = win_q;
  assign state     = state_q;
  assign time_left = time_left_q;
  assign timeout   = timeout_q;
  assign foul      = foul_q;

endmodule

// File: doc/responder_arbiter.md
RESPONDER_ARBITER -- requirements
Module: responder_arbiter

Interface
REQ-001 Parameter DEB_CYCLES, default 4: number of consecutive stable samples a button needs before its debounced level changes.
REQ-002 Parameter TICK_DIV, default 10: number of clk cycles per answer-timer tick.
REQ-003 Parameter ANS_TICKS, default 30: answer window in ticks; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn  input  4  raw player buttons; 1 = pressed; asynchronous to clk.
REQ-007 start  input  1  host arm request; level, sampled each cycle.
REQ-008 clear  input  1  host clear request; level, sampled each cycle.
REQ-009 win  output  4  one-hot winning player; all-zero when no winner.
REQ-010 state  output  2  FSM state encoding: 0 IDLE, 1 ARMED, 2 LOCKED, 3 TIMEOUT.
REQ-011 time_left  output  8  answer ticks remaining.
REQ-012 timeout  output  1  one-cycle pulse when time_left reaches 0.
REQ-013 foul  output  4  sticky early-press flags (see Configuration).

Function
REQ-014 Each btn bit shall pass through a 2-flop synchronizer, then a per-bit debouncer whose output changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-015 A press event shall be a debounced 0->1 edge, lasting one cycle.
REQ-016 IDLE: win=0, time_left=0; start=1 shall move to ARMED on the next cycle.
REQ-017 ARMED: the first cycle with any press event shall move to LOCKED, set win to that player, load time_left=ANS_TICKS and clear the tick divider.
REQ-018 Simultaneous press events in the same cycle shall resolve by fixed priority: bit 0 highest, bit 3 lowest; exactly one win bit is set.
REQ-019 LOCKED: win shall hold, and further presses shall be ignored; time_left shall decrement by 1 every TICK_DIV cycles.
REQ-020 LOCKED: when time_left goes 1->0, timeout shall pulse for that cycle and state shall move to TIMEOUT; win shall hold.
REQ-021 TIMEOUT: win and time_left=0 shall hold until clear.
REQ-022 clear=1 in any state shall return to IDLE next cycle with win=0 and time_left=0; clear has priority over start and over press events in the same cycle.
REQ-023 start while ARMED, LOCKED or TIMEOUT shall be ignored.
REQ-024 Buttons already held (debounced high) on entry to ARMED shall not win; a new 0->1 edge is required.
REQ-025 Latency: debounced press to win valid shall be exactly 1 cycle; raw btn to win shall be 2 + DEB_CYCLES + 1 cycles.

Reset
REQ-026 rst=1 shall force state=IDLE, win=0, time_left=0, timeout=0, foul=0, and clear all synchronizer, debouncer and divider registers to 0.
REQ-027 rst asserted mid-operation, including mid-debounce and mid-countdown, shall take effect on the next edge with no partial state retained.

Configuration
REQ-028 Macro RESPONDER_FOUL_DETECT_EN shall control early-press (foul) detection.
REQ-029 With RESPONDER_FOUL_DETECT_EN defined:
- A press event in IDLE shall set the matching foul bit.
- Foul bits shall clear on clear or rst.
- A player with its foul bit set shall be excluded from arbitration in ARMED.
REQ-030 Without RESPONDER_FOUL_DETECT_EN: foul shall be tied to 0 and no player is ever excluded.

Verification (DEB_CYCLES=4, TICK_DIV=10, ANS_TICKS=30 unless stated)
REQ-031 rst, start, then btn[2] held for 10 cycles -> win=4'b0100 and state=2 exactly 7 cycles after the btn rise; time_left=30.
REQ-032 ARMED, btn[1] and btn[3] rise in the same cycle -> win=4'b0010.
REQ-033 btn[0] glitching high for 3 cycles in ARMED -> no win, state stays 1.
REQ-034 Lock, then wait 300 cycles -> timeout pulses for 1 cycle with time_left=0, state=3, win unchanged; then clear -> state=0, win=0.
REQ-035 Macro defined: btn[0] pressed in IDLE -> foul=4'b0001; start; btn[0] and btn[1] press together -> win=4'b0010.
REQ-036 rst asserted mid-countdown at time_left=12 -> next cycle all outputs at reset values.
